trace_capture: RTL and testbench

TRACE_CAPTURE -- requirements
Module: trace_capture

---
 rtl/trace_capture.sv | 86 ++++++++
 tb/tb_trace_capture.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/trace_capture.sv
// trace_capture: CPU PC/write-back trace FIFO with halt detection.
// Define TRACE_OVERWRITE_EN to overwrite the oldest entry on push-when-full (default: drop).
module trace_capture #(
  parameter int DEPTH = 8,
  parameter int HALT_CYCLES = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_en,
  input  logic [31:0]              i_pc,
  input  logic [31:0]              i_rf_data,
  input  logic                     i_ready,
  output logic                     o_valid,
  output logic [31:0]              o_pc,
  output logic [31:0]              o_rf_data,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full,
  output logic                     o_empty,
  output logic                     o_overflow,
  output logic                     o_halt
);
  localparam int AW = $clog2(DEPTH);
`ifdef TRACE_OVERWRITE_EN
  localparam bit OVW = 1'b1;
`else
  localparam bit OVW = 1'b0;
`endif
  typedef enum logic {RUN, HALT} state_t;
  state_t state;
  logic [31:0] mem_pc [DEPTH];
  logic [31:0] mem_rf [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [AW:0] count;
  logic [31:0] last_pc;
  logic captured;
  logic [7:0] rep, rep_inc;
  logic push, pop, wr, adv;
  always_comb begin
    o_full = count == (AW+1)'(DEPTH);
    o_empty = count == '0;
    o_valid = !o_empty;
    o_count = count;
    o_pc = mem_pc[rd_ptr];
    o_rf_data = mem_rf[rd_ptr];
    o_halt = state == HALT;
    push = i_en && (!captured || i_pc != last_pc);
    pop = o_valid && i_ready;
    // wr: tail slot written; adv: head moves (a pop, or an overwrite evicting the oldest)
    wr = push && (!o_full || pop || OVW);
    adv = pop || (push && o_full && OVW);
    rep_inc = (rep == 8'hFF) ? rep : rep + 8'd1;
  end
  always_ff @(posedge i_clk) begin
    if (wr) begin
      mem_pc[wr_ptr] <= i_pc;
      mem_rf[wr_ptr] <= i_rf_data;
    end
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
      o_overflow <= 1'b0;
      captured <= 1'b0;
      last_pc <= '0;
      rep <= '0;
      state <= RUN;
    end else begin
      if (wr) wr_ptr <= wr_ptr + 1'b1;
      if (adv) rd_ptr <= rd_ptr + 1'b1;
      if (wr && !adv) count <= count + 1'b1;
      else if (adv && !wr) count <= count - 1'b1;
      if (push && o_full && !pop) o_overflow <= 1'b1;
      if (push) begin
        captured <= 1'b1;
        last_pc <= i_pc;
        rep <= '0;
        state <= RUN;
      end else if (i_en) begin
        rep <= rep_inc;
        if (rep_inc >= 8'(HALT_CYCLES)) state <= HALT;
      end
    end
  end
endmodule

// File: tb/tb_trace_capture.sv
// tb_trace_capture: directed + randomized bench for trace_capture against a queue-based model.
module tb_trace_capture;
  localparam int DEPTH = 8;
  localparam int HALT_CYCLES = 4;
`ifdef TRACE_OVERWRITE_EN
  localparam bit OVW = 1'b1;
`else
  localparam bit OVW = 1'b0;
`endif
  logic i_clk = 0, i_rst = 1, i_en = 0, i_ready = 0;
  logic [31:0] i_pc = 0, i_rf_data = 0;
  logic o_valid, o_full, o_empty, o_overflow, o_halt;
  logic [31:0] o_pc, o_rf_data;
  logic [$clog2(DEPTH):0] o_count;
  int n_cmp = 0, n_err = 0;
  logic [63:0] q [$];
  bit m_cap, m_ovf, m_halt;
  logic [31:0] m_last;
  int m_rep;
  logic [31:0] popped, same_pc;

  trace_capture #(.DEPTH(DEPTH), .HALT_CYCLES(HALT_CYCLES)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_en(i_en), .i_pc(i_pc), .i_rf_data(i_rf_data),
    .i_ready(i_ready), .o_valid(o_valid), .o_pc(o_pc), .o_rf_data(o_rf_data),
    .o_count(o_count), .o_full(o_full), .o_empty(o_empty), .o_overflow(o_overflow),
    .o_halt(o_halt)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Model evaluated from the inputs and model state just before the edge
  task automatic model_step();
    bit push, pop, was_full;
    if (i_rst) begin
      q.delete();
      m_cap = 0; m_ovf = 0; m_halt = 0; m_rep = 0;
      return;
    end
    push = i_en && (!m_cap || i_pc != m_last);
    pop = q.size() > 0 && i_ready;
    was_full = q.size() == DEPTH;
    if (pop) void'(q.pop_front());
    if (push) begin
      if (was_full && !pop) begin
        m_ovf = 1;
        if (OVW) begin
          void'(q.pop_front());
          q.push_back({i_pc, i_rf_data});
        end
      end else q.push_back({i_pc, i_rf_data});
      m_cap = 1; m_last = i_pc; m_rep = 0; m_halt = 0;
    end else if (i_en) begin
      if (m_rep < 255) m_rep++;
      if (m_rep >= HALT_CYCLES) m_halt = 1;
    end
  endtask

  task automatic cyc(input bit en, input bit rst, input bit rdy, input logic [31:0] pc, input logic [31:0] rf);
    i_en = en; i_rst = rst; i_ready = rdy; i_pc = pc; i_rf_data = rf;
    model_step();
    @(posedge i_clk);
    #1;
    chk("count", 64'(o_count), 64'(q.size()));
    chk("valid", 64'(o_valid), 64'(q.size() != 0));
    chk("empty", 64'(o_empty), 64'(q.size() == 0));
    chk("full", 64'(o_full), 64'(q.size() == DEPTH));
    chk("overflow", 64'(o_overflow), 64'(m_ovf));
    chk("halt", 64'(o_halt), 64'(m_halt));
    if (q.size() != 0) chk("head", {o_pc, o_rf_data}, q[0]);
  endtask

  task automatic do_reset();
    cyc(0, 1, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
  endtask

  task automatic drain(output logic [31:0] last);
    last = 32'hDEAD_BEEF;
    for (int k = 0; k < DEPTH; k++) begin
      if (o_valid) last = o_pc;
      cyc(0, 0, 1, 0, 0);
    end
  endtask

  initial begin
    #1;
    // basic ordering
    do_reset();
    chk("rst_empty", 64'(o_empty), 64'd1);
    cyc(1, 0, 0, 32'h0, 32'h11);
    cyc(1, 0, 0, 32'h4, 32'h22);
    cyc(1, 0, 0, 32'h8, 32'h33);
    chk("b_count", 64'(o_count), 64'd3);
    chk("b_head", {o_pc, o_rf_data}, {32'h0, 32'h11});
    cyc(0, 0, 1, 0, 0);
    chk("b_pop1", {o_pc, o_rf_data}, {32'h4, 32'h22});
    cyc(0, 0, 1, 0, 0);
    chk("b_pop2", {o_pc, o_rf_data}, {32'h8, 32'h33});
    cyc(0, 0, 1, 0, 0);
    chk("b_empty", 64'(o_empty), 64'd1);
    // halt detection
    do_reset();
    for (int k = 0; k < 5; k++) cyc(1, 0, 0, 32'h20, 32'(k));
    chk("h_count", 64'(o_count), 64'd1);
    chk("h_halt", 64'(o_halt), 64'd1);
    cyc(1, 0, 0, 32'h24, 32'h5);
    chk("h_run", 64'(o_halt), 64'd0);
    chk("h_count2", 64'(o_count), 64'd2);
    // overflow on 9 pushes
    do_reset();
    for (int k = 0; k < 9; k++) cyc(1, 0, 0, 32'(4 * k), 32'(k));
    chk("o_full", 64'(o_full), 64'd1);
    chk("o_ovf", 64'(o_overflow), 64'd1);
    chk("o_head", 64'(o_pc), OVW ? 64'h4 : 64'h0);
    drain(popped);
    chk("o_tail", 64'(popped), OVW ? 64'h20 : 64'h1C);
    // push+pop while full
    do_reset();
    for (int k = 0; k < 8; k++) cyc(1, 0, 0, 32'(4 * k), 32'(k));
    cyc(1, 0, 1, 32'h40, 32'h99);
    chk("f_count", 64'(o_count), 64'd8);
    chk("f_ovf", 64'(o_overflow), 64'd0);
    drain(popped);
    chk("f_tail", 64'(popped), 64'h40);
    // reset mid-stream while halted
    do_reset();
    for (int k = 0; k < 5; k++) cyc(1, 0, 0, 32'h100 + 32'(4 * k), 32'(k));
    same_pc = 32'h110;
    for (int k = 0; k < 4; k++) cyc(1, 0, 0, same_pc, 0);
    chk("r_pre_halt", 64'(o_halt), 64'd1);
    chk("r_pre_cnt", 64'(o_count), 64'd5);
    cyc(1, 1, 0, same_pc, 0);
    chk("r_cnt", 64'(o_count), 64'd0);
    chk("r_halt", 64'(o_halt), 64'd0);
    cyc(1, 0, 0, same_pc, 32'h77);
    chk("r_first", 64'(o_count), 64'd1);
    // disabled capture
    for (int k = 0; k < 10; k++) cyc(0, 0, 0, 32'h200 + 32'(4 * k), 0);
    chk("d_count", 64'(o_count), 64'd1);
    for (int k = 0; k < 3; k++) cyc(1, 0, 0, same_pc, 0);
    chk("d_halt_pending", 64'(o_halt), 64'd0);
    cyc(1, 0, 0, same_pc, 0);
    chk("d_halt", 64'(o_halt), 64'd1);
    // randomized
    for (int k = 0; k < 2000; k++)
      cyc($urandom_range(0, 9) < 8, $urandom_range(0, 99) < 2, $urandom_range(0, 9) < 4,
          32'($urandom_range(0, 3) * 4), $urandom);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
